// File: rtl/bw_iodll_code_xfer.sv
// Slave-side DLL code transfer: captures the master delay code, qualifies lock,
// applies a lane offset and steps the slave code only inside granted update windows.
module bw_iodll_code_xfer #(
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned MAX_STEP = 2
) (
    input  logic       ddr_clk_in,
    input  logic       io_dll_reset_l,
    input  logic [4:0] lpf_out,
    input  logic       iodll_lock,
    input  logic       overflow,
    input  logic       strobe,
    input  logic [2:0] code_offset,
    input  logic       upd_win,
    output logic [4:0] slave_code,
    output logic       slave_lock,
    output logic       upd_ack,
    output logic       code_err
);

    localparam int unsigned CODE_W = 5;
    localparam int unsigned LCNT_W = 4;
    localparam int unsigned SUM_W  = 7;

    localparam logic [LCNT_W-1:0]       LCNT_MAX  = LCNT_W'(LOCK_CNT);
    localparam logic [CODE_W-1:0]       CODE_RST  = 5'b10000;
    localparam logic [CODE_W-1:0]       CODE_MAX  = 5'd31;
    localparam logic signed [SUM_W-1:0] STEP_S    = SUM_W'(MAX_STEP);
    localparam logic signed [SUM_W-1:0] SUM_MAX_S = 7'sd31;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        LOAD   = 2'd1,
        TRACK  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   master_q, master_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                lock_q, lock_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    logic signed [SUM_W-1:0] sum_c;
    logic signed [SUM_W-1:0] diff_c;
    logic [CODE_W-1:0]       target_c;
    logic                    clamp_c;

    // Capture, lock qualification and sticky error
    always_comb begin
        master_d = master_q;
        lcnt_d   = lcnt_q;
        if (strobe) master_d = lpf_out;
        if (!iodll_lock) begin
            lcnt_d = '0;
        end else if (strobe && overflow) begin
            lcnt_d = '0;
        end else if (strobe && (lcnt_q != LCNT_MAX)) begin
            lcnt_d = lcnt_q + LCNT_W'(1);
        end
        lock_d = (lcnt_q == LCNT_MAX);
        err_d  = err_q | clamp_c | (strobe & overflow);
    end

    // Offset target; 7-bit signed so code 31 plus +3 cannot wrap before clamping
    always_comb begin
        sum_c    = $signed({2'b00, master_q}) + $signed({{4{code_offset[2]}}, code_offset});
        clamp_c  = 1'b0;
        target_c = sum_c[CODE_W-1:0];
        if (sum_c < 0) begin
            target_c = '0;
            clamp_c  = 1'b1;
        end else if (sum_c > SUM_MAX_S) begin
            target_c = CODE_MAX;
            clamp_c  = 1'b1;
        end
        diff_c = $signed({2'b00, target_c}) - $signed({2'b00, code_q});
    end

    // Transfer FSM: next state, slave code and ack
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ack_d   = 1'b0;
        if (!iodll_lock) begin
            state_d = UNLOCK;
        end else begin
            case (state_q)
                UNLOCK: begin
                    // lcnt check masks the stale slave_lock in the cycle after a lock loss
                    if (lock_q && (lcnt_q == LCNT_MAX)) state_d = LOAD;
                end
                LOAD: begin
                    if (upd_win) begin
                        code_d  = target_c;
                        ack_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
                TRACK: begin
                    if (upd_win && (target_c != code_q)) begin
                        if (diff_c > STEP_S) begin
                            code_d = code_q + CODE_W'(MAX_STEP);
                        end else if (diff_c < -STEP_S) begin
                            code_d = code_q - CODE_W'(MAX_STEP);
                        end else begin
                            code_d = target_c;
                        end
                        ack_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (!upd_win) state_d = TRACK;
                end
                default: state_d = UNLOCK;
            endcase
        end
    end

    always_ff @(posedge ddr_clk_in or negedge io_dll_reset_l) begin
        if (!io_dll_reset_l) begin
            state_q  <= UNLOCK;
            master_q <= '0;
            lcnt_q   <= '0;
            code_q   <= CODE_RST;
            lock_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            lcnt_q   <= lcnt_d;
            code_q   <= code_d;
            lock_q   <= lock_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign slave_code = code_q;
    assign slave_lock = lock_q;
    assign upd_ack    = ack_q;
    assign code_err   = err_q;

endmodule

// File: tb/tb_bw_iodll_code_xfer.sv
// Directed bench for bw_iodll_code_xfer: per-cycle vector table plus clamp, reset and overflow sequences.
module tb_bw_iodll_code_xfer;

    logic       clk;
    logic       rst_n;
    logic [4:0] lpf_out;
    logic       iodll_lock;
    logic       overflow;
    logic       strobe;
    logic [2:0] code_offset;
    logic       upd_win;
    logic [4:0] slave_code;
    logic       slave_lock;
    logic       upd_ack;
    logic       code_err;

    int checks = 0;
    int errors = 0;

    bw_iodll_code_xfer #(.LOCK_CNT(8), .MAX_STEP(2)) dut (
        .ddr_clk_in    (clk),
        .io_dll_reset_l(rst_n),
        .lpf_out       (lpf_out),
        .iodll_lock    (iodll_lock),
        .overflow      (overflow),
        .strobe        (strobe),
        .code_offset   (code_offset),
        .upd_win       (upd_win),
        .slave_code    (slave_code),
        .slave_lock    (slave_lock),
        .upd_ack       (upd_ack),
        .code_err      (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] lpf;
        logic       lock;
        logic       ovf;
        logic       stb;
        logic [2:0] off;
        logic       win;
        logic [4:0] code;
        logic       slk;
        logic       ack;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] lpf, input logic lock, input logic ovf, input logic stb,
                       input logic [2:0] off, input logic win, input logic [4:0] code,
                       input logic slk, input logic ack, input logic err);
        vec_t v;
        v.lpf = lpf; v.lock = lock; v.ovf = ovf; v.stb = stb; v.off = off; v.win = win;
        v.code = code; v.slk = slk; v.ack = ack; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_once(input logic [4:0] code, input logic ovf);
        lpf_out = code; overflow = ovf; strobe = 1'b1;
        tick();
        strobe = 1'b0; overflow = 1'b0;
    endtask

    // Pulse the update window maxw times, counting acks
    task automatic windows(input int maxw, output int acks);
        acks = 0;
        repeat (maxw) begin
            upd_win = 1'b1;
            tick();
            if (upd_ack) acks++;
            upd_win = 1'b0;
            tick();
        end
    endtask

    initial begin
        int acks;
        rst_n = 1'b0; lpf_out = '0; iodll_lock = 1'b0; overflow = 1'b0;
        strobe = 1'b0; code_offset = '0; upd_win = 1'b0;

        // Lock, load, tracking steps, held window, lock loss in HOLD, relock with fresh strobes
        for (int i = 0; i < 8; i++) add(20, 1, 0, 1, 0, 0, 16, 0, 0, 0);
        add(20, 1, 0, 0, 0, 0, 16, 1, 0, 0);
        add(20, 1, 0, 0, 0, 0, 16, 1, 0, 0);
        add(20, 1, 0, 0, 0, 1, 20, 1, 1, 0);
        add(20, 1, 0, 0, 0, 0, 20, 1, 0, 0);
        add(26, 1, 0, 1, 0, 0, 20, 1, 0, 0);
        add(26, 1, 0, 0, 0, 1, 22, 1, 1, 0);
        add(26, 1, 0, 0, 0, 0, 22, 1, 0, 0);
        add(26, 1, 0, 0, 0, 1, 24, 1, 1, 0);
        add(26, 1, 0, 0, 0, 0, 24, 1, 0, 0);
        add(26, 1, 0, 0, 0, 1, 26, 1, 1, 0);
        add(26, 1, 0, 0, 0, 0, 26, 1, 0, 0);
        add(26, 1, 0, 0, 0, 1, 26, 1, 0, 0);
        add(26, 1, 0, 0, 0, 0, 26, 1, 0, 0);
        add(30, 1, 0, 1, 0, 0, 26, 1, 0, 0);
        add(30, 1, 0, 0, 0, 1, 28, 1, 1, 0);
        add(30, 1, 0, 0, 0, 1, 28, 1, 0, 0);
        add(30, 1, 0, 0, 0, 1, 28, 1, 0, 0);
        add(30, 0, 0, 0, 0, 1, 28, 1, 0, 0);
        add(30, 0, 0, 0, 0, 1, 28, 0, 0, 0);
        add(30, 1, 0, 0, 0, 1, 28, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(10, 1, 0, 1, 0, 0, 28, 0, 0, 0);
        add(10, 1, 0, 0, 0, 0, 28, 1, 0, 0);
        add(10, 1, 0, 0, 0, 0, 28, 1, 0, 0);
        add(10, 1, 0, 0, 0, 1, 10, 1, 1, 0);
        add(10, 1, 0, 0, 0, 0, 10, 1, 0, 0);

        tick(); tick();
        chk("reset_outputs", {24'd0, slave_code, slave_lock, upd_ack, code_err}, {24'd0, 5'd16, 3'b000});
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            lpf_out = tbl[i].lpf; iodll_lock = tbl[i].lock; overflow = tbl[i].ovf;
            strobe = tbl[i].stb; code_offset = tbl[i].off; upd_win = tbl[i].win;
            tick();
            chk($sformatf("row%0d code/lock/ack/err", i),
                {24'd0, slave_code, slave_lock, upd_ack, code_err},
                {24'd0, tbl[i].code, tbl[i].slk, tbl[i].ack, tbl[i].err});
        end
        strobe = 1'b0; upd_win = 1'b0;

        // Upper clamp: 30 + 3 saturates at 31 and flags the error
        code_offset = 3'b011;
        strobe_once(5'd30, 1'b0);
        tick();
        chk("clamp_hi_err", {31'd0, code_err}, 32'd1);
        chk("clamp_hi_code_held", {27'd0, slave_code}, 32'd10);
        windows(14, acks);
        chk("clamp_hi_code", {27'd0, slave_code}, 32'd31);
        chk("clamp_hi_acks", acks, 32'd11);

        // Lower clamp: 2 - 4 saturates at 0
        code_offset = 3'b100;
        strobe_once(5'd2, 1'b0);
        tick();
        windows(20, acks);
        chk("clamp_lo_code", {27'd0, slave_code}, 32'd0);
        chk("clamp_lo_acks", acks, 32'd16);
        chk("clamp_lo_err_sticky", {31'd0, code_err}, 32'd1);

        // Asynchronous reset mid-cycle while tracking with the error set
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {24'd0, slave_code, slave_lock, upd_ack, code_err}, {24'd0, 5'd16, 3'b000});
        tick();
        rst_n = 1'b1; code_offset = '0; iodll_lock = 1'b1;

        // Overflow strobe at lcnt=5 clears the qualifier and sets the error
        for (int i = 0; i < 5; i++) strobe_once(5'd12, 1'b0);
        chk("pre_ovf_err", {31'd0, code_err}, 32'd0);
        strobe_once(5'd12, 1'b1);
        chk("ovf_err", {31'd0, code_err}, 32'd1);
        chk("ovf_lock", {31'd0, slave_lock}, 32'd0);
        for (int i = 0; i < 7; i++) strobe_once(5'd12, 1'b0);
        tick(); tick();
        chk("ovf_lock_after7", {31'd0, slave_lock}, 32'd0);
        strobe_once(5'd12, 1'b0);
        chk("ovf_lock_at8_edge", {31'd0, slave_lock}, 32'd0);
        tick();
        chk("ovf_relock", {31'd0, slave_lock}, 32'd1);
        chk("ovf_code_held", {27'd0, slave_code}, 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
